memops_pipe: RTL and testbench

Parametrised, pipelined Wishbone load/store unit for the RISC-V core's memory stage. It accepts one load or store per cycle from the operand stage and routes it to the global or local bus by address. It keeps up to DEPTH reads or writes outstanding in one bus cycle, then returns sign- or zero-extended load data with its destination register to write-back. It detects misaligned accesses, illegal widths and bus errors itself.

---
 rtl/memops_pipe_if.sv | 33 +++
 rtl/memops_pipe.sv | 249 ++++++++++++++++++++++++
 tb/tb_memops_pipe.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memops_pipe_if.sv
// Wishbone-side bundle of the memory-stage load/store unit.
// One shared response channel serves both the global and the local bus;
// the unit raises cyc/stb on exactly one of them at a time.
interface memops_pipe_if #(
  parameter int XLEN = 32
);
  localparam int LGB = $clog2(XLEN/8);

  logic                o_wb_gbl_cyc;
  logic                o_wb_gbl_stb;
  logic                o_wb_lcl_cyc;
  logic                o_wb_lcl_stb;
  logic                o_wb_we;
  logic [XLEN-LGB-1:0] o_wb_addr;
  logic [XLEN-1:0]     o_wb_data;
  logic [XLEN/8-1:0]   o_wb_sel;
  logic                i_wb_stall;
  logic                i_wb_ack;
  logic                i_wb_err;
  logic [XLEN-1:0]     i_wb_data;

  modport master (
    output o_wb_gbl_cyc, o_wb_gbl_stb, o_wb_lcl_cyc, o_wb_lcl_stb,
    output o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
    input  i_wb_stall, i_wb_ack, i_wb_err, i_wb_data
  );

  modport slave (
    input  o_wb_gbl_cyc, o_wb_gbl_stb, o_wb_lcl_cyc, o_wb_lcl_stb,
    input  o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
    output i_wb_stall, i_wb_ack, i_wb_err, i_wb_data
  );
endinterface

// File: rtl/memops_pipe.sv
// Pipelined Wishbone load/store unit for the memory stage.
// Accepts one request per cycle, keeps up to DEPTH accesses of one class
// (same bus, same direction) outstanding inside a single bus cycle, and
// returns extended load data in order with its destination register.
module memops_pipe #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] LCL_MASK = 'hFF00_0000,
  parameter logic [XLEN-1:0] LCL_BASE = 'hFF00_0000
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_ce,
  input  logic [3:0]      i_op,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_data,
  input  logic [4:0]      i_wreg,
  output logic            o_busy,
  output logic            o_rdbusy,
  output logic            o_pipe_stalled,
  output logic            o_valid,
  output logic            o_err,
  output logic [4:0]      o_wreg,
  output logic [XLEN-1:0] o_result,
  memops_pipe_if.master   wb
);

  localparam int LGB  = $clog2(XLEN/8);
  localparam int AW   = XLEN - LGB;
  localparam int SELW = XLEN/8;
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH+1);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic {S_IDLE, S_BUS} state_t;

  // What the ack path needs to format a returning word.
  typedef struct packed {
    logic [4:0]     wreg;
    logic [2:0]     f3;
    logic [LGB-1:0] off;
  } req_t;

  state_t          state;
  logic            stb_r;
  logic            cur_lcl;
  logic            cur_we;
  logic [AW-1:0]   addr_r;
  logic [XLEN-1:0] data_r;
  logic [SELW-1:0] sel_r;
  logic [CW-1:0]   count;
  logic [PW:0]     wr_ptr;
  logic [PW:0]     rd_ptr;
  req_t            fifo_mem [DEPTH];

  logic            req_store;
  logic [2:0]      req_f3;
  logic            req_lcl;
  logic            req_legal;
  logic            req_misalign;
  logic            req_ok;
  logic [XLEN-1:0] st_data;
  logic [SELW-1:0] st_mask;
  logic [SELW-1:0] st_sel;
  logic [PW:0]     fill;
  logic            class_hit;
  logic            accept;
  logic            issue;
  logic            bad;
  logic            load_new;
  logic            stb_take;
  logic            ack_ok;
  logic [CW-1:0]   count_nx;
  req_t            head;
  logic [XLEN-1:0] ld_shift;
  logic [XLEN-1:0] ld_data;

  // Decode the incoming request: legality, alignment, target bus, store lanes.
  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    req_store    = i_op[3];
    req_f3       = i_op[2:0];
    req_lcl      = ((i_addr & LCL_MASK) == LCL_BASE);
    req_legal    = 1'b0;
    req_misalign = 1'b0;
    st_data      = i_data;
    st_mask      = '1;
    if (req_store) begin
      case (req_f3)
        3'b000, 3'b001, 3'b010: req_legal = 1'b1;
        3'b011:                 req_legal = (XLEN == 64);
        default:                req_legal = 1'b0;
      endcase
    end else begin
      case (req_f3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_legal = 1'b1;
        3'b011, 3'b110:                         req_legal = (XLEN == 64);
        default:                                req_legal = 1'b0;
      endcase
    end
    case (req_f3[1:0])
      2'd0: begin
        req_misalign = 1'b0;
        st_data      = {SELW{i_data[7:0]}};
        st_mask      = SELW'(1);
      end
      2'd1: begin
        req_misalign = i_addr[0];
        st_data      = {(XLEN/16){i_data[15:0]}};
        st_mask      = SELW'(3);
      end
      2'd2: begin
        req_misalign = |i_addr[1:0];
        st_data      = {(XLEN/32){i_data[31:0]}};
        st_mask      = SELW'(15);
      end
      default: begin
        req_misalign = |i_addr[2:0];
        st_data      = i_data;
        st_mask      = '1;
      end
    endcase
    st_sel = st_mask << i_addr[LGB-1:0];
    req_ok = req_legal && !req_misalign;
  end

  // Acceptance: inside an open cycle only same-class requests may join, and
  // only while the FIFO has room and the held strobe is not being stalled.
  always_comb begin
    fill      = wr_ptr - rd_ptr;
    class_hit = (req_lcl == cur_lcl) && (req_store == cur_we);
    o_pipe_stalled = (state == S_BUS) &&
                     ((fill == FULL) || (stb_r && wb.i_wb_stall) ||
                      (req_ok && !class_hit));
    accept   = i_ce && !o_pipe_stalled;
    issue    = accept && req_ok;
    bad      = accept && !req_ok;
    // A request accepted in the same cycle as a bus error belongs to the
    // failed cycle: it is dropped and covered by that cycle's error pulse.
    load_new = issue && !((state == S_BUS) && wb.i_wb_err);
    stb_take = stb_r && !wb.i_wb_stall;
    ack_ok   = (state == S_BUS) && wb.i_wb_ack && (count != '0);
    count_nx = count + CW'(stb_take) - CW'(ack_ok);
  end

  // Format the returning word using the oldest outstanding request.
  always_comb begin
    head     = fifo_mem[rd_ptr[PW-1:0]];
    ld_shift = wb.i_wb_data >> {head.off, 3'b000};
    ld_data  = ld_shift;
    case (head.f3)
      3'b000:  ld_data = XLEN'($signed(ld_shift[7:0]));
      3'b001:  ld_data = XLEN'($signed(ld_shift[15:0]));
      3'b010:  ld_data = XLEN'($signed(ld_shift[31:0]));
      3'b100:  ld_data = XLEN'(ld_shift[7:0]);
      3'b101:  ld_data = XLEN'(ld_shift[15:0]);
      3'b110:  ld_data = XLEN'(ld_shift[31:0]);
      default: ld_data = ld_shift;
    endcase
  end

  // Request FIFO storage: written on every issue, read at the head on ack.
  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are live, so resetting the array would only add reset fan-out.
  always_ff @(posedge i_clk) begin
    if (load_new)
      fifo_mem[wr_ptr[PW-1:0]] <= '{wreg: i_wreg, f3: req_f3, off: i_addr[LGB-1:0]};
  end

  // Bus-cycle state machine with its registered strobes, counters and results.
  // NOTE: all state here updates with non-blocking assignments so every
  // branch sees the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= S_IDLE;
      stb_r    <= 1'b0;
      cur_lcl  <= 1'b0;
      cur_we   <= 1'b0;
      addr_r   <= '0;
      data_r   <= '0;
      sel_r    <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      o_valid  <= 1'b0;
      o_err    <= 1'b0;
      o_wreg   <= '0;
      o_result <= '0;
    end else begin
      o_valid <= 1'b0;
      o_err   <= bad;
      case (state)
        S_IDLE: begin
          if (issue) begin
            state <= S_BUS;
            stb_r <= 1'b1;
          end
        end
        S_BUS: begin
          if (wb.i_wb_err) begin
            state  <= S_IDLE;
            stb_r  <= 1'b0;
            count  <= '0;
            rd_ptr <= wr_ptr;
            o_err  <= 1'b1;
          end else begin
            count <= count_nx;
            if (ack_ok) begin
              rd_ptr   <= rd_ptr + 1'b1;
              o_valid  <= !cur_we;
              o_result <= ld_data;
              o_wreg   <= head.wreg;
            end
            if (issue) begin
              stb_r <= 1'b1;
            end else begin
              if (stb_take)
                stb_r <= 1'b0;
              if ((count_nx == '0) && !(stb_r && wb.i_wb_stall))
                state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
      if (load_new) begin
        addr_r  <= i_addr[XLEN-1:LGB];
        data_r  <= st_data;
        sel_r   <= st_sel;
        cur_lcl <= req_lcl;
        cur_we  <= req_store;
        wr_ptr  <= wr_ptr + 1'b1;
      end
    end
  end

  assign o_busy          = (state == S_BUS);
  assign o_rdbusy        = o_busy && !cur_we;
  assign wb.o_wb_gbl_cyc = o_busy && !cur_lcl;
  assign wb.o_wb_gbl_stb = stb_r && !cur_lcl;
  assign wb.o_wb_lcl_cyc = o_busy && cur_lcl;
  assign wb.o_wb_lcl_stb = stb_r && cur_lcl;
  assign wb.o_wb_we      = cur_we;
  assign wb.o_wb_addr    = addr_r;
  assign wb.o_wb_data    = data_r;
  assign wb.o_wb_sel     = sel_r;

endmodule

// File: tb/tb_memops_pipe.sv
// Directed bench for memops_pipe (XLEN=32, DEPTH=4). The Wishbone slave is
// played by hand: stall/ack/err/data are driven at the falling edge so they
// are stable across the next rising edge, and outputs are sampled there too.
module tb_memops_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_ce;
  logic [3:0]  i_op;
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic [4:0]  i_wreg;
  logic        o_busy, o_rdbusy, o_pipe_stalled, o_valid, o_err;
  logic [4:0]  o_wreg;
  logic [31:0] o_result;

  int n_checks = 0;
  int n_err    = 0;

  memops_pipe_if #(.XLEN(32)) wb ();

  memops_pipe #(.XLEN(32), .DEPTH(4)) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_ce           (i_ce),
    .i_op           (i_op),
    .i_addr         (i_addr),
    .i_data         (i_data),
    .i_wreg         (i_wreg),
    .o_busy         (o_busy),
    .o_rdbusy       (o_rdbusy),
    .o_pipe_stalled (o_pipe_stalled),
    .o_valid        (o_valid),
    .o_err          (o_err),
    .o_wreg         (o_wreg),
    .o_result       (o_result),
    .wb             (wb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] data, input logic [4:0] wreg);
    i_ce   = 1'b1;
    i_op   = op;
    i_addr = addr;
    i_data = data;
    i_wreg = wreg;
  endtask

  // One isolated load on the global bus, ack one cycle after the strobe.
  task automatic single_load(input string tag, input logic [3:0] op, input logic [31:0] addr,
                             input logic [4:0] wreg, input logic [31:0] rdata,
                             input logic [3:0] exp_sel, input logic [31:0] exp_res);
    drive(op, addr, 32'h0, wreg);
    #1 check({tag, " stall"}, o_pipe_stalled, 1'b0);
    @(negedge clk);
    i_ce = 1'b0;
    check({tag, " gbl_cyc"}, wb.o_wb_gbl_cyc, 1'b1);
    check({tag, " gbl_stb"}, wb.o_wb_gbl_stb, 1'b1);
    check({tag, " lcl_cyc"}, wb.o_wb_lcl_cyc, 1'b0);
    check({tag, " sel"}, wb.o_wb_sel, exp_sel);
    check({tag, " addr"}, wb.o_wb_addr, addr >> 2);
    check({tag, " rdbusy"}, o_rdbusy, 1'b1);
    @(negedge clk);
    check({tag, " stb drop"}, wb.o_wb_gbl_stb, 1'b0);
    check({tag, " cyc hold"}, wb.o_wb_gbl_cyc, 1'b1);
    wb.i_wb_ack  = 1'b1;
    wb.i_wb_data = rdata;
    @(negedge clk);
    wb.i_wb_ack = 1'b0;
    check({tag, " valid"}, o_valid, 1'b1);
    check({tag, " result"}, o_result, exp_res);
    check({tag, " wreg"}, o_wreg, wreg);
    check({tag, " cyc end"}, wb.o_wb_gbl_cyc, 1'b0);
    @(negedge clk);
    check({tag, " valid end"}, o_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    i_ce = 1'b0; i_op = '0; i_addr = '0; i_data = '0; i_wreg = '0;
    wb.i_wb_stall = 1'b0; wb.i_wb_ack = 1'b0; wb.i_wb_err = 1'b0; wb.i_wb_data = '0;
    repeat (2) @(negedge clk);
    check("rst busy", o_busy, 1'b0);
    check("rst valid", o_valid, 1'b0);
    check("rst err", o_err, 1'b0);
    check("rst gbl_cyc", wb.o_wb_gbl_cyc, 1'b0);
    check("rst lcl_stb", wb.o_wb_lcl_stb, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic loads: word, signed/unsigned byte, unsigned half.
    single_load("lw",  4'b0010, 32'h0000_1000, 5'd5, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF);
    single_load("lb",  4'b0000, 32'h0000_1003, 5'd6, 32'h8012_3456, 4'h8, 32'hFFFF_FF80);
    single_load("lbu", 4'b0100, 32'h0000_1003, 5'd6, 32'h8012_3456, 4'h8, 32'h0000_0080);
    single_load("lhu", 4'b0101, 32'h0000_1002, 5'd8, 32'h8012_3456, 4'hC, 32'h0000_8012);

    // Half-word store to the local bus.
    drive(4'b1001, 32'hFF00_0002, 32'hABCD_1234, 5'd0);
    @(negedge clk);
    i_ce = 1'b0;
    check("sh lcl_cyc", wb.o_wb_lcl_cyc, 1'b1);
    check("sh gbl_cyc", wb.o_wb_gbl_cyc, 1'b0);
    check("sh sel", wb.o_wb_sel, 4'hC);
    check("sh data", wb.o_wb_data, 32'h1234_1234);
    check("sh we", wb.o_wb_we, 1'b1);
    check("sh addr", wb.o_wb_addr, 30'h3FC0_0000);
    check("sh rdbusy", o_rdbusy, 1'b0);
    @(negedge clk);
    wb.i_wb_ack = 1'b1;
    @(negedge clk);
    wb.i_wb_ack = 1'b0;
    check("sh no valid", o_valid, 1'b0);
    check("sh cyc end", wb.o_wb_lcl_cyc, 1'b0);
    @(negedge clk);

    // Four back-to-back loads fill DEPTH; the fifth waits for the first ack.
    drive(4'b0010, 32'h0000_2000, 32'h0, 5'd1);
    @(negedge clk);
    drive(4'b0010, 32'h0000_2004, 32'h0, 5'd2);
    #1 check("b2b stall2", o_pipe_stalled, 1'b0);
    @(negedge clk);
    drive(4'b0010, 32'h0000_2008, 32'h0, 5'd3);
    @(negedge clk);
    drive(4'b0010, 32'h0000_200C, 32'h0, 5'd4);
    #1 check("b2b stall4", o_pipe_stalled, 1'b0);
    @(negedge clk);
    drive(4'b0010, 32'h0000_2010, 32'h0, 5'd9);
    #1 check("b2b stall5 full", o_pipe_stalled, 1'b1);
    @(negedge clk);
    check("b2b stall5 hold", o_pipe_stalled, 1'b1);
    wb.i_wb_ack = 1'b1; wb.i_wb_data = 32'h1111_1111;
    @(negedge clk);
    check("b2b v1", o_valid, 1'b1);
    check("b2b r1", o_result, 32'h1111_1111);
    check("b2b w1", o_wreg, 5'd1);
    check("b2b stall5 free", o_pipe_stalled, 1'b0);
    wb.i_wb_data = 32'h2222_2222;
    @(negedge clk);
    i_ce = 1'b0;
    check("b2b r2", o_result, 32'h2222_2222);
    check("b2b w2", o_wreg, 5'd2);
    wb.i_wb_data = 32'h3333_3333;
    @(negedge clk);
    check("b2b w3", o_wreg, 5'd3);
    wb.i_wb_data = 32'h4444_4444;
    @(negedge clk);
    check("b2b r4", o_result, 32'h4444_4444);
    check("b2b w4", o_wreg, 5'd4);
    wb.i_wb_data = 32'h5555_5555;
    @(negedge clk);
    wb.i_wb_ack = 1'b0;
    check("b2b v5", o_valid, 1'b1);
    check("b2b r5", o_result, 32'h5555_5555);
    check("b2b w5", o_wreg, 5'd9);
    @(negedge clk);
    check("b2b idle", o_busy, 1'b0);

    // Slave stall: strobe and address hold, the next request waits behind it.
    wb.i_wb_stall = 1'b1;
    drive(4'b0010, 32'h0000_6000, 32'h0, 5'd14);
    @(negedge clk);
    drive(4'b0001, 32'h0000_6006, 32'h0, 5'd15);
    #1 check("stl pipe", o_pipe_stalled, 1'b1);
    check("stl stb1", wb.o_wb_gbl_stb, 1'b1);
    check("stl addr1", wb.o_wb_addr, 30'h1800);
    @(negedge clk);
    check("stl stb2", wb.o_wb_gbl_stb, 1'b1);
    check("stl addr2", wb.o_wb_addr, 30'h1800);
    wb.i_wb_stall = 1'b0;
    #1 check("stl pipe free", o_pipe_stalled, 1'b0);
    @(negedge clk);
    i_ce = 1'b0;
    check("stl stb3", wb.o_wb_gbl_stb, 1'b1);
    check("stl addr3", wb.o_wb_addr, 30'h1801);
    check("stl sel3", wb.o_wb_sel, 4'hC);
    wb.i_wb_ack = 1'b1; wb.i_wb_data = 32'h0000_7FFF;
    @(negedge clk);
    check("stl r1", o_result, 32'h0000_7FFF);
    check("stl w1", o_wreg, 5'd14);
    wb.i_wb_data = 32'h8001_0000;
    @(negedge clk);
    wb.i_wb_ack = 1'b0;
    check("stl lh r2", o_result, 32'hFFFF_8001);
    check("stl w2", o_wreg, 5'd15);
    check("stl cyc end", wb.o_wb_gbl_cyc, 1'b0);
    @(negedge clk);

    // Misaligned word load, then an illegal store width.
    drive(4'b0010, 32'h0000_1002, 32'h0, 5'd7);
    @(negedge clk);
    drive(4'b1100, 32'h0000_1000, 32'h0, 5'd0);
    check("mis err", o_err, 1'b1);
    check("mis no cyc", wb.o_wb_gbl_cyc, 1'b0);
    check("mis busy", o_busy, 1'b0);
    @(negedge clk);
    i_ce = 1'b0;
    check("ill err", o_err, 1'b1);
    check("ill no cyc", wb.o_wb_gbl_cyc | wb.o_wb_lcl_cyc, 1'b0);
    @(negedge clk);
    check("ill err end", o_err, 1'b0);

    // Bus error with two loads outstanding.
    drive(4'b0010, 32'h0000_3000, 32'h0, 5'd10);
    @(negedge clk);
    drive(4'b0010, 32'h0000_3004, 32'h0, 5'd11);
    @(negedge clk);
    i_ce = 1'b0;
    @(negedge clk);
    check("berr busy", o_busy, 1'b1);
    wb.i_wb_err = 1'b1;
    @(negedge clk);
    wb.i_wb_err = 1'b0;
    check("berr err", o_err, 1'b1);
    check("berr cyc", wb.o_wb_gbl_cyc, 1'b0);
    check("berr valid", o_valid, 1'b0);
    wb.i_wb_ack = 1'b1;
    @(negedge clk);
    wb.i_wb_ack = 1'b0;
    check("berr late ack", o_valid, 1'b0);
    check("berr err once", o_err, 1'b0);
    @(negedge clk);

    // Global load followed by local store: store waits for gbl_cyc to fall.
    drive(4'b0010, 32'h0000_4000, 32'h0, 5'd12);
    @(negedge clk);
    drive(4'b1010, 32'hFF00_0010, 32'hCAFE_F00D, 5'd0);
    #1 check("x stall1", o_pipe_stalled, 1'b1);
    @(negedge clk);
    check("x stall2", o_pipe_stalled, 1'b1);
    wb.i_wb_ack = 1'b1; wb.i_wb_data = 32'h0BAD_CAFE;
    @(negedge clk);
    wb.i_wb_ack = 1'b0;
    check("x gbl down", wb.o_wb_gbl_cyc, 1'b0);
    check("x ld valid", o_valid, 1'b1);
    check("x ld result", o_result, 32'h0BAD_CAFE);
    #1 check("x stall free", o_pipe_stalled, 1'b0);
    @(negedge clk);
    i_ce = 1'b0;
    check("x lcl_cyc", wb.o_wb_lcl_cyc, 1'b1);
    check("x lcl_stb", wb.o_wb_lcl_stb, 1'b1);
    check("x gbl idle", wb.o_wb_gbl_cyc, 1'b0);
    check("x st data", wb.o_wb_data, 32'hCAFE_F00D);
    check("x st addr", wb.o_wb_addr, 30'h3FC0_0004);
    @(negedge clk);
    wb.i_wb_ack = 1'b1;
    @(negedge clk);
    wb.i_wb_ack = 1'b0;
    check("x st no valid", o_valid, 1'b0);
    check("x lcl down", wb.o_wb_lcl_cyc, 1'b0);

    // Reset in the middle of an open load cycle.
    drive(4'b0010, 32'h0000_5000, 32'h0, 5'd13);
    @(negedge clk);
    i_ce = 1'b0;
    check("rm cyc up", wb.o_wb_gbl_cyc, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("rm cyc", wb.o_wb_gbl_cyc, 1'b0);
    check("rm stb", wb.o_wb_gbl_stb, 1'b0);
    check("rm busy", o_busy, 1'b0);
    wb.i_wb_ack = 1'b1; wb.i_wb_data = 32'h7777_7777;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wb.i_wb_ack = 1'b0;
    check("rm no valid", o_valid, 1'b0);
    check("rm idle", o_busy, 1'b0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
